// File: rtl/pw_trigger_seq_pkg.sv
// Shared types and helpers for the pulse-train trigger sequencer.
//   pw_state_e : sequencer state encoding (IDLE, DELAY, HIGH, HOLDOFF)
//   MISSED_W   : width of the saturating missed-match counter
//   max3       : elaboration-time helper used to size the shared down-counter
package pw_trigger_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DELAY   = 2'd1,
    ST_HIGH    = 2'd2,
    ST_HOLDOFF = 2'd3
  } pw_state_e;

  localparam int MISSED_W = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pw_sat_counter.sv
// Event counter with synchronous clear and selectable saturate/wrap.
//   trigger_clk, reset_n : clock, async active-low reset
//   i_inc                : count one event this cycle
//   i_clear              : zero the counter (wins over i_inc)
//   o_count              : current count
module pw_sat_counter #(
  parameter int pWIDTH    = 8,
  parameter bit pSATURATE = 1'b0
) (
  input  logic              trigger_clk,
  input  logic              reset_n,
  input  logic              i_inc,
  input  logic              i_clear,
  output logic [pWIDTH-1:0] o_count
);

  logic [pWIDTH-1:0] r_count;

  always_ff @(posedge trigger_clk or negedge reset_n) begin
    if (!reset_n)
      r_count <= '0;
    else if (i_clear)
      r_count <= '0;
    else if (i_inc && !(pSATURATE && (r_count == '1)))
      r_count <= r_count + pWIDTH'(1);
  end

  assign o_count = r_count;

endmodule

// File: rtl/pw_trigger_seq.sv
// Parametrised pulse-train trigger generator (trigger_clk domain).
// On an accepted match emits up to pNUM_PULSES delay/width pulses on
// O_trigger, then a holdoff. Supports one-shot arming, abort on disable
// and accepted/missed statistics.
//   I_match / I_arm / I_clear_counts : single-cycle pulses
//   I_trigger_enable, I_oneshot      : levels
//   I_num_triggers, I_holdoff        : snapshotted at acceptance
//   I_trigger_delay/width            : packed per-pulse fields
//   O_trigger, O_busy, O_armed, O_seq_count, O_missed_count
module pw_trigger_seq
  import pw_trigger_seq_pkg::*;
#(
  parameter int pNUM_PULSES        = 16,
  parameter int pDELAY_WIDTH       = 20,
  parameter int pWIDTH_WIDTH       = 17,
  parameter int pHOLDOFF_WIDTH     = 24,
  parameter int pNUM_TRIGGER_WIDTH = $clog2(pNUM_PULSES + 1),
  parameter int pSEQ_COUNT_WIDTH   = 16
) (
  input  logic                                  trigger_clk,
  input  logic                                  reset_n,
  input  logic                                  I_match,
  input  logic                                  I_trigger_enable,
  input  logic                                  I_oneshot,
  input  logic                                  I_arm,
  input  logic                                  I_clear_counts,
  input  logic [pNUM_TRIGGER_WIDTH-1:0]         I_num_triggers,
  input  logic [pNUM_PULSES*pDELAY_WIDTH-1:0]   I_trigger_delay,
  input  logic [pNUM_PULSES*pWIDTH_WIDTH-1:0]   I_trigger_width,
  input  logic [pHOLDOFF_WIDTH-1:0]             I_holdoff,
  output logic                                  O_trigger,
  output logic                                  O_busy,
  output logic                                  O_armed,
  output logic [pSEQ_COUNT_WIDTH-1:0]           O_seq_count,
  output logic [MISSED_W-1:0]                   O_missed_count
);

  localparam int CNT_W = max3(pDELAY_WIDTH, pWIDTH_WIDTH, pHOLDOFF_WIDTH);
  localparam int IDX_W = (pNUM_PULSES > 1) ? $clog2(pNUM_PULSES) : 1;
  localparam logic [pNUM_TRIGGER_WIDTH-1:0] MAX_N = pNUM_TRIGGER_WIDTH'(pNUM_PULSES);

  logic [pNUM_PULSES-1:0][pDELAY_WIDTH-1:0] w_dly_arr;
  logic [pNUM_PULSES-1:0][pWIDTH_WIDTH-1:0] w_wid_arr;
  assign w_dly_arr = I_trigger_delay;
  assign w_wid_arr = I_trigger_width;

  pw_state_e                     r_state, w_state_nxt;
  logic [CNT_W-1:0]              r_cnt, w_cnt_nxt;
  logic [pNUM_TRIGGER_WIDTH-1:0] r_idx, w_idx_nxt;
  logic [pNUM_TRIGGER_WIDTH-1:0] r_n, w_n_nxt;
  logic [pHOLDOFF_WIDTH-1:0]     r_holdoff, w_holdoff_nxt;
  logic [pDELAY_WIDTH-1:0]       r_dly, w_dly_nxt;
  logic [pWIDTH_WIDTH-1:0]       r_wid, w_wid_nxt;
  logic                          r_trigger, w_trigger_nxt;
  logic                          r_armed;

  logic [pNUM_TRIGGER_WIDTH-1:0] w_n_eff, w_idx_inc;
  logic [IDX_W-1:0]              w_nidx;
  logic [CNT_W-1:0]              w_wid_m1, w_dly_m1, w_hold_m1;
  logic                          w_accept, w_missed;

  assign w_n_eff  = (I_num_triggers > MAX_N) ? MAX_N : I_num_triggers;
  assign O_armed  = I_oneshot ? r_armed : 1'b1;
  assign w_accept = (r_state == ST_IDLE) & I_match & I_trigger_enable & O_armed
                  & (w_n_eff != '0);
  assign w_missed = I_match & I_trigger_enable & ~w_accept;

  // Field for the next pulse; past the last field the value is never used.
  assign w_idx_inc = r_idx + pNUM_TRIGGER_WIDTH'(1);
  assign w_nidx    = (w_idx_inc < MAX_N) ? w_idx_inc[IDX_W-1:0] : '0;

  // Zero-length width/gap fields are stretched to one cycle.
  assign w_wid_m1  = (r_wid == '0) ? '0 : CNT_W'(r_wid - pWIDTH_WIDTH'(1));
  assign w_dly_m1  = (r_dly == '0) ? '0 : CNT_W'(r_dly - pDELAY_WIDTH'(1));
  assign w_hold_m1 = CNT_W'(r_holdoff - pHOLDOFF_WIDTH'(1));

  always_ff @(posedge trigger_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_n       <= '0;
      r_holdoff <= '0;
      r_dly     <= '0;
      r_wid     <= '0;
      r_trigger <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_idx     <= w_idx_nxt;
      r_n       <= w_n_nxt;
      r_holdoff <= w_holdoff_nxt;
      r_dly     <= w_dly_nxt;
      r_wid     <= w_wid_nxt;
      r_trigger <= w_trigger_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_idx_nxt     = r_idx;
    w_n_nxt       = r_n;
    w_holdoff_nxt = r_holdoff;
    w_dly_nxt     = r_dly;
    w_wid_nxt     = r_wid;
    w_trigger_nxt = r_trigger;
    if (!I_trigger_enable) begin
      // Abort: straight back to IDLE, no holdoff.
      w_state_nxt   = ST_IDLE;
      w_trigger_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            w_state_nxt   = ST_DELAY;
            w_cnt_nxt     = CNT_W'(w_dly_arr[0]);  // D0 of 0 rises on the next edge
            w_wid_nxt     = w_wid_arr[0];
            w_idx_nxt     = '0;
            w_n_nxt       = w_n_eff;
            w_holdoff_nxt = I_holdoff;
          end
        end
        ST_DELAY: begin
          if (r_cnt == '0) begin
            w_state_nxt   = ST_HIGH;
            w_trigger_nxt = 1'b1;
            w_cnt_nxt     = w_wid_m1;
            // Prefetch the following pulse's fields while this one is high.
            w_dly_nxt     = w_dly_arr[w_nidx];
            w_wid_nxt     = w_wid_arr[w_nidx];
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
        ST_HIGH: begin
          if (r_cnt == '0) begin
            w_trigger_nxt = 1'b0;
            if (w_idx_inc == r_n) begin
              if (r_holdoff == '0) begin
                w_state_nxt = ST_IDLE;
              end else begin
                w_state_nxt = ST_HOLDOFF;
                w_cnt_nxt   = w_hold_m1;
              end
            end else begin
              w_state_nxt = ST_DELAY;
              w_idx_nxt   = w_idx_inc;
              w_cnt_nxt   = w_dly_m1;
            end
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
        ST_HOLDOFF: begin
          if (r_cnt == '0) w_state_nxt = ST_IDLE;
          else             w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Acceptance clears the arm flag even if I_arm arrives on the same edge.
  always_ff @(posedge trigger_clk or negedge reset_n) begin
    if (!reset_n)                   r_armed <= 1'b0;
    else if (I_oneshot && w_accept) r_armed <= 1'b0;
    else if (I_oneshot && I_arm)    r_armed <= 1'b1;
  end

  assign O_trigger = r_trigger;
  assign O_busy    = (r_state != ST_IDLE);

  pw_sat_counter #(.pWIDTH(pSEQ_COUNT_WIDTH), .pSATURATE(1'b0)) u_seq_cnt (
    .trigger_clk (trigger_clk),
    .reset_n     (reset_n),
    .i_inc       (w_accept),
    .i_clear     (I_clear_counts),
    .o_count     (O_seq_count)
  );

  pw_sat_counter #(.pWIDTH(MISSED_W), .pSATURATE(1'b1)) u_missed_cnt (
    .trigger_clk (trigger_clk),
    .reset_n     (reset_n),
    .i_inc       (w_missed),
    .i_clear     (I_clear_counts),
    .o_count     (O_missed_count)
  );

endmodule
